pipe_hazard_ctrl: RTL

- Hazard and sequencing controller for the 5-stage RV32 pipeline; drives stall, flush and forwarding controls for the fetch/decode/execute/memory/writeback registers.
- Resolves load-use hazards, taken-branch flushes and multi-cycle data-memory waits.
- Watchdogs memory waits and keeps saturating stall/flush event counters for debug.

---
 rtl/pipe_ctrl_pkg.sv | 34 +++
 rtl/hazard_fwd_unit.sv | 29 ++
 rtl/pipe_hazard_ctrl.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the RV32 pipeline hazard controller.
package pipe_ctrl_pkg;

    // Sequencing states of the hazard controller
    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERR      = 2'd2
    } state_e;

    // Operand source selects for the execute-stage ALU inputs
    localparam logic [1:0] FWD_RF = 2'b00;
    localparam logic [1:0] FWD_W  = 2'b01;
    localparam logic [1:0] FWD_M  = 2'b10;

    // Forward select for one execute source register; memory stage wins over writeback
    function automatic logic [1:0] fwd_sel(
        input logic [4:0] rs,
        input logic [4:0] rd_m,
        input logic       we_m,
        input logic [4:0] rd_w,
        input logic       we_w
    );
        logic [1:0] sel;
        sel = FWD_RF;
        if (we_m && (rd_m != 5'd0) && (rd_m == rs)) begin
            sel = FWD_M;
        end else if (we_w && (rd_w != 5'd0) && (rd_w == rs)) begin
            sel = FWD_W;
        end
        return sel;
    endfunction

endpackage

// File: rtl/hazard_fwd_unit.sv
// Combinational operand forwarding for both execute-stage source registers.
module hazard_fwd_unit
    import pipe_ctrl_pkg::*;
(
    input  logic [4:0] RS1_E,
    input  logic [4:0] RS2_E,
    input  logic [4:0] RD_M,
    input  logic       RegWriteM,
    input  logic [4:0] RD_W,
    input  logic       RegWriteW,
    output logic [1:0] ForwardAE,
    output logic [1:0] ForwardBE
);

    logic [4:0] rs_e [2];
    logic [1:0] fwd  [2];

    assign rs_e[0] = RS1_E;
    assign rs_e[1] = RS2_E;

    // Same priority rule applied independently to each operand
    for (genvar gi = 0; gi < 2; gi++) begin : g_operand
        assign fwd[gi] = fwd_sel(rs_e[gi], RD_M, RegWriteM, RD_W, RegWriteW);
    end

    assign ForwardAE = fwd[0];
    assign ForwardBE = fwd[1];

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard and sequencing controller for the 5-stage RV32 pipeline:
// load-use stalls, taken-branch flushes, data-memory waits with a watchdog,
// operand forwarding and saturating stall/flush debug counters.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 64,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       RS1_D,
    input  logic [4:0]       RS2_D,
    input  logic [4:0]       RS1_E,
    input  logic [4:0]       RS2_E,
    input  logic [4:0]       RD_E,
    input  logic             MemReadE,
    input  logic             PCSrcE,
    input  logic [4:0]       RD_M,
    input  logic             RegWriteM,
    input  logic             MemReqM,
    input  logic             MemReadyM,
    input  logic [4:0]       RD_W,
    input  logic             RegWriteW,
    input  logic             cnt_clr,
    output logic             StallF,
    output logic             StallD,
    output logic             StallE,
    output logic             StallM,
    output logic             FlushD,
    output logic             FlushE,
    output logic             FlushW,
    output logic [1:0]       ForwardAE,
    output logic [1:0]       ForwardBE,
    output logic             MemErr,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    // Wait counter only needs to reach MEM_TIMEOUT
    localparam int                WAIT_W      = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;
    localparam logic [WAIT_W-1:0] TIMEOUT_VAL = WAIT_W'(MEM_TIMEOUT);
    localparam logic [WAIT_W-1:0] WAIT_MAX    = '1;
    localparam logic [CNT_W-1:0]  CNT_MAX     = '1;

    state_e             state_q, state_d;
    logic [WAIT_W-1:0]  wait_cnt_q, wait_cnt_d;
    logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]   flush_cnt_q, flush_cnt_d;
    logic               mem_err_q, mem_err_d;

    logic               lu_haz;
    logic               mem_busy;
    logic               br_flush;
    logic               any_stall;
    logic [1:0]         fwd_a, fwd_b;

    assign lu_haz   = MemReadE && (RD_E != 5'd0) && ((RD_E == RS1_D) || (RD_E == RS2_D));
    assign mem_busy = MemReqM && !MemReadyM;

    hazard_fwd_unit u_fwd (
        .RS1_E     (RS1_E),
        .RS2_E     (RS2_E),
        .RD_M      (RD_M),
        .RegWriteM (RegWriteM),
        .RD_W      (RD_W),
        .RegWriteW (RegWriteW),
        .ForwardAE (fwd_a),
        .ForwardBE (fwd_b)
    );

    // Forwarding is neutral while the pipeline is being reset
    assign ForwardAE = rst ? FWD_RF : fwd_a;
    assign ForwardBE = rst ? FWD_RF : fwd_b;

    // Mealy stall/flush decode: reset bubbles, then memory freeze, branch, load-use
    always_comb begin
        StallF   = 1'b0;
        StallD   = 1'b0;
        StallE   = 1'b0;
        StallM   = 1'b0;
        FlushD   = 1'b0;
        FlushE   = 1'b0;
        FlushW   = 1'b0;
        br_flush = 1'b0;
        if (rst) begin
            FlushD = 1'b1;
            FlushE = 1'b1;
            FlushW = 1'b1;
        end else if ((state_q == ERR) || mem_busy) begin
            // Execute is frozen, so branch and load-use are re-presented later
            StallF = 1'b1;
            StallD = 1'b1;
            StallE = 1'b1;
            StallM = 1'b1;
            FlushW = 1'b1;
        end else if (PCSrcE) begin
            // A load-use on the wrong-path decode instruction is irrelevant
            FlushD   = 1'b1;
            FlushE   = 1'b1;
            br_flush = 1'b1;
        end else if (lu_haz) begin
            StallF = 1'b1;
            StallD = 1'b1;
            FlushE = 1'b1;
        end
    end

    assign any_stall = StallF | StallD | StallE | StallM;

    // Sequencing FSM with memory-wait watchdog
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        mem_err_d  = mem_err_q;
        case (state_q)
            RUN: begin
                if (mem_busy) begin
                    state_d    = MEM_WAIT;
                    wait_cnt_d = WAIT_W'(1);
                end
            end
            MEM_WAIT: begin
                if (MemReadyM) begin
                    state_d    = RUN;
                    wait_cnt_d = '0;
                end else if (mem_busy) begin
                    if ((MEM_TIMEOUT != 0) && (wait_cnt_q == TIMEOUT_VAL)) begin
                        state_d   = ERR;
                        mem_err_d = 1'b1;
                    end else if (wait_cnt_q != WAIT_MAX) begin
                        wait_cnt_d = wait_cnt_q + WAIT_W'(1);
                    end
                end
            end
            ERR: begin
                state_d = ERR;
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    // Saturating debug counters; clear beats increment
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (cnt_clr) begin
            stall_cnt_d = '0;
            flush_cnt_d = '0;
        end else begin
            if (any_stall && (stall_cnt_q != CNT_MAX)) begin
                stall_cnt_d = stall_cnt_q + CNT_W'(1);
            end
            if (br_flush && (flush_cnt_q != CNT_MAX)) begin
                flush_cnt_d = flush_cnt_q + CNT_W'(1);
            end
        end
    end

    // State and counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= RUN;
            wait_cnt_q  <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
            mem_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
            mem_err_q   <= mem_err_d;
        end
    end

    assign MemErr    = mem_err_q;
    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

endmodule
